// File: rtl/demux4x32_wb.sv
// 1-to-4 registered write-back demultiplexer with per-slot valid/ready handshake.
// Each slot is a 1-entry holding register, so a stalled consumer blocks only its own slot.
module demux4x32_wb #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [1:0]       s,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             v0,
   output logic             v1,
   output logic             v2,
   output logic             v3,
   input  logic             r0,
   input  logic             r1,
   input  logic             r2,
   input  logic             r3,
   output logic             busy,
   output logic [CNTW-1:0]  cnt
);

   logic [WIDTH-1:0] y_q [4];
   logic [3:0]       v_q;
   logic [3:0]       r_vec;
   logic [3:0]       acc_vec;
   logic [3:0]       drn_vec;
   logic [CNTW-1:0]  cnt_q;
   logic             accept;

   assign r_vec    = {r3, r2, r1, r0};
   assign in_ready = !rst && (!v_q[s] || r_vec[s]);
   assign accept   = in_valid && in_ready;

   always_comb begin
      acc_vec = '0;
      if (accept) acc_vec = 4'b0001 << s;
   end

   // A slot accepted this cycle is refilled, not drained, so it stays valid.
   assign drn_vec = v_q & r_vec & ~acc_vec;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < 4; k++) y_q[k] <= '0;
         v_q   <= '0;
         cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (acc_vec[k]) y_q[k] <= a;
         end
         v_q <= (v_q & ~drn_vec) | acc_vec;
         if (accept) cnt_q <= cnt_q + CNTW'(1);
      end
   end

   assign y0   = y_q[0];
   assign y1   = y_q[1];
   assign y2   = y_q[2];
   assign y3   = y_q[3];
   assign v0   = v_q[0];
   assign v1   = v_q[1];
   assign v2   = v_q[2];
   assign v3   = v_q[3];
   assign busy = |v_q;
   assign cnt  = cnt_q;

endmodule

// File: tb/tb_demux4x32_wb.sv
// Self-checking bench for demux4x32_wb: directed scenarios plus random traffic
// compared against a slot-array reference model.
module tb_demux4x32_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a;
   logic [1:0]  s;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] y0, y1, y2, y3;
   logic        v0, v1, v2, v3;
   logic        r0, r1, r2, r3;
   logic        busy;
   logic [7:0]  cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference model state
   logic [31:0] my [4];
   logic [3:0]  mv;
   int unsigned mcnt;

   always #5 clk = ~clk;

   demux4x32_wb #(.WIDTH(32), .CNTW(8)) dut (
      .clk(clk), .rst(rst), .a(a), .s(s), .in_valid(in_valid), .in_ready(in_ready),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .v0(v0), .v1(v1), .v2(v2), .v3(v3),
      .r0(r0), .r1(r1), .r2(r2), .r3(r3),
      .busy(busy), .cnt(cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, check in_ready before the edge, step the model, check state after.
   task automatic cycle(input logic r_st, input logic iv, input logic [1:0] ss,
                        input logic [31:0] aa, input logic [3:0] rr);
      logic        exp_rdy;
      logic [31:0] yv [4];
      logic [3:0]  vv;
      @(negedge clk);
      rst = r_st; in_valid = iv; s = ss; a = aa;
      {r3, r2, r1, r0} = rr;
      #1;
      exp_rdy = !r_st && (!mv[ss] || rr[ss]);
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      @(posedge clk);
      if (r_st) begin
         for (int k = 0; k < 4; k++) my[k] = '0;
         mv   = '0;
         mcnt = 0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (mv[k] && rr[k]) mv[k] = 1'b0;
         if (iv && exp_rdy) begin
            my[ss] = aa;
            mv[ss] = 1'b1;
            mcnt   = (mcnt + 1) % 256;
         end
      end
      #1;
      yv[0] = y0; yv[1] = y1; yv[2] = y2; yv[3] = y3;
      vv = {v3, v2, v1, v0};
      for (int k = 0; k < 4; k++) begin
         check($sformatf("y%0d", k), {32'd0, yv[k]}, {32'd0, my[k]});
         check($sformatf("v%0d", k), {63'd0, vv[k]}, {63'd0, mv[k]});
      end
      check("cnt", {56'd0, cnt}, 64'(mcnt));
      check("busy", {63'd0, busy}, {63'd0, (mv != 4'd0)});
   endtask

   initial begin
      rst = 1'b0; a = '0; s = '0; in_valid = 1'b0;
      {r3, r2, r1, r0} = '0;
      for (int k = 0; k < 4; k++) my[k] = '0;
      mv = '0; mcnt = 0;

      // 1: reset
      cycle(1'b1, 1'b1, 2'd0, 32'hAAAA5555, 4'h0);
      check("rst_cnt", {56'd0, cnt}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);

      // 2: accept to slot 2, then a blocked second offer
      cycle(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'h0);
      check("t2_y2", {32'd0, y2}, {32'd0, 32'hDEADBEEF});
      check("t2_cnt", {56'd0, cnt}, 64'd1);
      cycle(1'b0, 1'b1, 2'd2, 32'hCAFEF00D, 4'h0);
      check("t2_hold_y2", {32'd0, y2}, {32'd0, 32'hDEADBEEF});

      // 3: simultaneous drain and refill of slot 2
      cycle(1'b0, 1'b1, 2'd2, 32'h12345678, 4'b0100);
      check("t3_y2", {32'd0, y2}, {32'd0, 32'h12345678});
      check("t3_v2", {63'd0, v2}, 64'd1);

      // 4: slot 2 stalled, other slots still accept
      cycle(1'b0, 1'b1, 2'd0, 32'd1, 4'h0);
      cycle(1'b0, 1'b1, 2'd3, 32'd3, 4'h0);
      check("t4_y0", {32'd0, y0}, 64'd1);
      check("t4_y3", {32'd0, y3}, 64'd3);
      check("t4_y2", {32'd0, y2}, {32'd0, 32'h12345678});

      // 5: drains, data held, busy falls
      cycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b0001);
      check("t5_v0", {63'd0, v0}, 64'd0);
      check("t5_y0", {32'd0, y0}, 64'd1);
      cycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b1100);
      check("t5_busy", {63'd0, busy}, 64'd0);

      // 6: counter wrap with back-to-back accepts, then reset mid-burst
      cycle(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
      for (int i = 0; i < 256; i++)
         cycle(1'b0, 1'b1, 2'd1, 32'(i) ^ 32'h5A5A0000, 4'b0010);
      check("t6_wrap", {56'd0, cnt}, 64'd0);
      check("t6_last", {32'd0, y1}, {32'd0, 32'h5A5A00FF});
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 1'b1, 2'(i), 32'hF0000000 + 32'(i), 4'h0);
      cycle(1'b1, 1'b1, 2'd1, 32'hBAD0BAD0, 4'h2);
      check("t6_rst_v", {60'd0, v3, v2, v1, v0}, 64'd0);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
               $urandom, 4'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
